var_delay_ctrl: RTL and testbench
=================================

# var_delay_ctrl

Run-time programmable delay-line controller for the signed 25-bit sample datapath. It replaces the team's fixed-depth shift-register delays wherever alignment depth must change without a rebuild. Samples are stored in a circular register buffer with a valid tag per entry. A small state machine handles reconfiguration: it accepts a new depth through a valid/ready handshake, discards in-flight samples and holds off the output until the line has refilled.

## Interface
- DW, 25, sample width (signed)
- MAX_DELAY, 16, largest supported delay in cycles (>= 2)
- RESET_DELAY, 6, delay in force after reset (1..MAX_DELAY)
- DLY_W, $clog2(MAX_DELAY+1), width of delay values (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- din  input  DW  signed sample in
- din_valid  input  1  sample qualifier, delayed alongside din
- dout  output  DW  signed delayed sample; reset 0
- dout_valid  output  1  delayed din_valid, masked during fill; reset 0
- cfg_delay  input  DLY_W  requested delay in cycles
- cfg_valid  input  1  reconfiguration request
- cfg_ready  output  1  high only in RUN; reset 0
- cur_delay  output  DLY_W  delay currently in force; reset RESET_DELAY
- cfg_err  output  1  only with VAR_DELAY_STRICT_EN; reset 0

## Operation
- Line advances every clock, like a shift register, and is not gated by din_valid.
- {din_valid, din} captured at edge t appears on {dout_valid, dout} after edge t+D, where D = cur_delay.
- D=1 behaves as a single register stage.
- States are FILL and RUN.
- Reset:
  - Buffer tags cleared, write pointer 0, cur_delay = RESET_DELAY, state FILL.
  - Fill counter loaded with RESET_DELAY.
- FILL:
  - cfg_ready=0.
  - Input is still written into the buffer.
  - dout and dout_valid forced to 0.
  - Counter decrements each cycle; at 1 → RUN.
- RUN:
  - cfg_ready=1.
  - Output follows the buffer.
  - Handshake when cfg_valid && cfg_ready at edge k:
    - cur_delay ← clamp(cfg_delay).
    - All buffer valid tags cleared.
    - Counter ← new D; state → FILL.
  - Samples captured at edge k+1 onward use the new D.
  - Samples in flight at the old delay are discarded, never emitted.
- Clamp: 0 → 1; values > MAX_DELAY → MAX_DELAY.
- cfg_valid in FILL is ignored. The requester holds it until cfg_ready.
- Write pointer wraps modulo MAX_DELAY. The read position is derived from the write pointer and D with the same wrap.
- No arithmetic on samples; dout is bit-exact to din.

## Timing
- Latency is exactly D clocks, for D from 1 to MAX_DELAY.
- Outputs are registered; there is no combinational din→dout path.
- After reset deasserts, dout_valid stays 0 for RESET_DELAY cycles. The first valid output is the sample captured at the first edge with reset low.
- After a handshake at edge k:
  - Outputs after edges k+1..k+D are suppressed.
  - Output after edge k+1+D is the sample captured at edge k+1.
  - cfg_ready falls after edge k and rises after edge k+D.
- cur_delay updates after edge k.
- Reset asserted mid-FILL or mid-RUN overrides everything at that edge and returns to the reset state.
- Reset has priority over a simultaneous handshake.

## Configuration
- VAR_DELAY_STRICT_EN undefined:
  - Out-of-range requests are clamped as above.
  - cfg_err is tied 0.
- VAR_DELAY_STRICT_EN defined:
  - An out-of-range request (0 or > MAX_DELAY) still completes the handshake.
  - It is otherwise discarded: cur_delay unchanged, no FILL, tags kept, output undisturbed.
  - cfg_err pulses high for one cycle after the accepting edge.
  - In-range requests behave as in the default build.

## Structure
- Package var_delay_pkg holds:
  - State typedef (ST_FILL, ST_RUN).
  - Default DW.
  - Clamp function.
- Sub-module var_delay_buf: MAX_DELAY×(DW+1) circular register storage, write pointer, registered read, synchronous tag clear.
- Top-level var_delay_ctrl holds the FSM, fill counter, clamp/strict logic and output masking.

## Test plan
- Reset, then ramp din=1,2,3… with din_valid=1 → dout_valid rises 6 cycles after reset drops; dout=1 first, then tracks din with latency 6.
- In RUN, request cfg_delay=3 → cfg_ready low for 3 cycles; dout_valid low 3 cycles; then latency 3; no old-delay sample emitted.
- cfg_delay=16 and cfg_delay=1 → latency 16 and 1 respectively; wrap exercised over ≥40 samples without a glitch.
- cfg_delay=0 and cfg_delay=20:
  - Default build: cur_delay 1 and 16 respectively.
  - Strict build: one-cycle cfg_err, cur_delay unchanged, stream uninterrupted.
- Alternating din_valid pattern 1,0,0,1 → dout_valid reproduces the pattern shifted by D.
- Reset asserted mid-FILL after a reconfiguration → outputs 0 and cur_delay=6 next cycle, then normal 6-cycle fill.

Source files
------------

// File: rtl/var_delay_pkg.sv
// Shared types and helpers for the run-time programmable delay line.
// Holds the FSM state encoding, the default sample width and the delay clamp.
package var_delay_pkg;

  localparam int VD_DW = 25;

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } state_e;

  // Out-of-range requests snap to the nearest legal delay (1..maxDelay).
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned maxDelay);
    if (req == 0) return 1;
    if (req > maxDelay) return maxDelay;
    return req;
  endfunction

endpackage

// File: rtl/var_delay_buf.sv
// Circular register storage for {valid, sample} with a registered read port.
// The read slot trails the write pointer by delay_i entries, modulo MAX_DELAY.
module var_delay_buf #(
  parameter int DW        = 25,
  parameter int MAX_DELAY = 16,
  parameter int DLY_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             wr_valid_i,
  input  logic [DLY_W-1:0] delay_i,
  input  logic             clr_tags_i,
  input  logic             zero_out_i,
  output logic [DW-1:0]    rd_data_o,
  output logic             rd_valid_o
);

  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

  logic [DW-1:0]        data_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] tag_q;
  logic [PW-1:0]        wp_q;
  logic [DW-1:0]        rdData_q;
  logic                 rdValid_q;
  logic [DLY_W:0]       idxSum;
  logic [PW-1:0]        rdIdx;

  // For D == MAX_DELAY the read slot equals the write slot; the read sees the old entry.
  always_comb begin
    idxSum = (DLY_W+1)'(wp_q) + (DLY_W+1)'(MAX_DELAY) - (DLY_W+1)'(delay_i);
    if (idxSum >= (DLY_W+1)'(MAX_DELAY)) begin
      rdIdx = PW'(idxSum - (DLY_W+1)'(MAX_DELAY));
    end else begin
      rdIdx = PW'(idxSum);
    end
  end

  always_ff @(posedge clk) begin
    data_q[wp_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q     <= '0;
      wp_q      <= '0;
      rdData_q  <= '0;
      rdValid_q <= 1'b0;
    end else begin
      if (clr_tags_i) begin
        tag_q <= '0;
      end else begin
        tag_q[wp_q] <= wr_valid_i;
      end
      wp_q <= (wp_q == PW'(MAX_DELAY - 1)) ? '0 : wp_q + PW'(1);
      if (zero_out_i) begin
        rdData_q  <= '0;
        rdValid_q <= 1'b0;
      end else begin
        rdData_q  <= data_q[rdIdx];
        rdValid_q <= tag_q[rdIdx];
      end
    end
  end

  assign rd_data_o  = rdData_q;
  assign rd_valid_o = rdValid_q;

endmodule

// File: rtl/var_delay_ctrl.sv
// Programmable delay-line controller: reconfiguration FSM, fill counter and output masking.
// Optional build macro VAR_DELAY_STRICT_EN rejects out-of-range requests and flags cfg_err.
module var_delay_ctrl
  import var_delay_pkg::*;
#(
  parameter int DW          = VD_DW,
  parameter int MAX_DELAY   = 16,
  parameter int RESET_DELAY = 6,
  localparam int DLY_W      = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DW-1:0]    din,
  input  logic             din_valid,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [DLY_W-1:0] cur_delay,
  output logic             cfg_err
);

  state_e           state_q, state_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic [DLY_W-1:0] cur_q, cur_d;
  logic [DLY_W-1:0] reqClamped;
  logic             clrTags;
  logic             accept;
`ifdef VAR_DELAY_STRICT_EN
  logic             err_q, err_d;
  logic             reqInRange;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FILL;
      cnt_q   <= DLY_W'(RESET_DELAY);
      cur_q   <= DLY_W'(RESET_DELAY);
`ifdef VAR_DELAY_STRICT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
`ifdef VAR_DELAY_STRICT_EN
      err_q   <= err_d;
`endif
    end
  end

  // An accepted request flushes the tags and refills for exactly the new delay.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    clrTags    = 1'b0;
    reqClamped = DLY_W'(clamp_delay(32'(cfg_delay), MAX_DELAY));
    accept     = cfg_valid && (state_q == ST_RUN);
`ifdef VAR_DELAY_STRICT_EN
    err_d      = 1'b0;
    reqInRange = (cfg_delay != '0) && (cfg_delay <= DLY_W'(MAX_DELAY));
`endif
    case (state_q)
      ST_FILL: begin
        if (cnt_q <= DLY_W'(1)) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      ST_RUN: begin
        if (accept) begin
`ifdef VAR_DELAY_STRICT_EN
          if (!reqInRange) begin
            err_d = 1'b1;
          end else begin
            cur_d   = reqClamped;
            cnt_d   = reqClamped;
            state_d = ST_FILL;
            clrTags = 1'b1;
          end
`else
          cur_d   = reqClamped;
          cnt_d   = reqClamped;
          state_d = ST_FILL;
          clrTags = 1'b1;
`endif
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  var_delay_buf #(
    .DW        (DW),
    .MAX_DELAY (MAX_DELAY),
    .DLY_W     (DLY_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .wr_data_i  (din),
    .wr_valid_i (din_valid),
    .delay_i    (cur_q),
    .clr_tags_i (clrTags),
    .zero_out_i (state_q == ST_FILL),
    .rd_data_o  (dout),
    .rd_valid_o (dout_valid)
  );

  assign cfg_ready = (state_q == ST_RUN);
  assign cur_delay = cur_q;
`ifdef VAR_DELAY_STRICT_EN
  assign cfg_err   = err_q;
`else
  assign cfg_err   = 1'b0;
`endif

endmodule

// File: tb/tb_var_delay_ctrl.sv
// Directed bench for var_delay_ctrl: din is a ramp (value captured at edge x is x+1),
// so every expected output is a closed-form function of the edge number and the delay.
module tb_var_delay_ctrl;

  localparam int DW = 25;
  localparam int DLY_W = 5;
`ifdef VAR_DELAY_STRICT_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [DW-1:0]    din;
  logic             din_valid;
  logic [DW-1:0]    dout;
  logic             dout_valid;
  logic [DLY_W-1:0] cfg_delay;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DLY_W-1:0] cur_delay;
  logic             cfg_err;

  int nCompared = 0;
  int nFail     = 0;
  int e         = -1;
  int curD      = 6;
  int fillEnd   = 5;
  int patStart  = 0;
  int patEnd    = 0;

  var_delay_ctrl #(.DW(DW), .MAX_DELAY(16), .RESET_DELAY(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .cfg_delay  (cfg_delay),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cur_delay  (cur_delay),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // din_valid follows 1,0,0,1 inside the pattern window, otherwise stays high.
  function automatic logic srcValid(input int x);
    if (x >= patStart && x < patEnd) return (x % 4 == 0) || (x % 4 == 3);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    nCompared++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s at edge %0d: observed=%0d expected=%0d", tag, e, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
    e++;
    din       = DW'(e + 2);
    din_valid = srcValid(e + 1);
  endtask

  task automatic runPhase(input int lastEdge);
    while (e < lastEdge) begin
      applyStimulus();
      if (e > fillEnd) begin
        checkOutput("dout", int'(dout), e - curD + 1);
        checkOutput("dout_valid", int'(dout_valid), int'(srcValid(e - curD)));
      end else begin
        checkOutput("dout_fill", int'(dout), 0);
        checkOutput("dout_valid_fill", int'(dout_valid), 0);
      end
      checkOutput("cfg_ready", int'(cfg_ready), int'(e >= fillEnd));
      checkOutput("cur_delay", int'(cur_delay), curD);
      checkOutput("cfg_err", int'(cfg_err), 0);
    end
  endtask

  task automatic doCfg(input int req, input int expNewD, input bit isBad);
    cfg_valid = 1'b1;
    cfg_delay = DLY_W'(req);
    applyStimulus();
    cfg_valid = 1'b0;
    cfg_delay = '0;
    checkOutput("dout_hs", int'(dout), e - curD + 1);
    checkOutput("dout_valid_hs", int'(dout_valid), int'(srcValid(e - curD)));
    if (isBad) begin
      checkOutput("cfg_err_bad", int'(cfg_err), 1);
      checkOutput("cfg_ready_bad", int'(cfg_ready), 1);
      checkOutput("cur_delay_bad", int'(cur_delay), curD);
    end else begin
      checkOutput("cfg_err_hs", int'(cfg_err), 0);
      checkOutput("cfg_ready_hs", int'(cfg_ready), 0);
      checkOutput("cur_delay_hs", int'(cur_delay), expNewD);
      curD    = expNewD;
      fillEnd = e + expNewD;
    end
  endtask

  initial begin
    reset     = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    cfg_delay = '0;
    cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_dout_valid", int'(dout_valid), 0);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 0);
    checkOutput("rst_cur_delay", int'(cur_delay), 6);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);

    $display("[TB] initial fill and ramp at delay 6");
    reset     = 1'b0;
    din       = DW'(1);
    din_valid = 1'b1;
    runPhase(19);

    $display("[TB] reconfigure to 3");
    doCfg(3, 3, 1'b0);
    runPhase(fillEnd + 12);

    $display("[TB] delay 16 and delay 1 with pointer wrap");
    doCfg(16, 16, 1'b0);
    runPhase(fillEnd + 40);
    doCfg(1, 1, 1'b0);
    runPhase(fillEnd + 40);

    $display("[TB] out-of-range requests 0 and 20");
    doCfg(0, 1, STRICT);
    runPhase(e + 12);
    doCfg(20, 16, STRICT);
    runPhase(e + 24);

    $display("[TB] din_valid pattern 1,0,0,1 at delay 4");
    doCfg(4, 4, 1'b0);
    patStart  = e + 1;
    patEnd    = 1000000;
    din_valid = srcValid(e + 1);
    runPhase(fillEnd + 24);
    patEnd    = e + 1;
    din_valid = srcValid(e + 1);

    $display("[TB] reset during fill after reconfiguration");
    doCfg(8, 8, 1'b0);
    runPhase(e + 3);
    reset = 1'b1;
    applyStimulus();
    checkOutput("midrst_dout", int'(dout), 0);
    checkOutput("midrst_dout_valid", int'(dout_valid), 0);
    checkOutput("midrst_cfg_ready", int'(cfg_ready), 0);
    checkOutput("midrst_cur_delay", int'(cur_delay), 6);
    checkOutput("midrst_cfg_err", int'(cfg_err), 0);
    reset   = 1'b0;
    curD    = 6;
    fillEnd = e + 6;
    runPhase(e + 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
    $finish;
  end

endmodule
